inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch stage directly downstream of the program counter. It accepts the current fetch address and the PC's return address (PC+4). It issues one request at a time to instruction memory over a req/gnt/rvalid handshake. Fetched words are buffered with their PC in a small FIFO that feeds decode through a valid/ready handshake. A flush from branch/jump/COP0 redirect discards buffered and in-flight fetches.

Parameters:
FIFO_DEPTH, 2, entries in the output buffer (power of two, >=2)
NOP_INST, 32'h0000_0000, value driven on id_inst when id_valid=0

Ports:
clk  input  1  clock, all state on rising edge
rest_n  input  1  asynchronous active-low reset
pc_addr  input  32  fetch address from PC
pc_rt_addr  input  32  PC+4 return address paired with pc_addr
pc_valid  input  1  pc_addr/pc_rt_addr valid this cycle
pc_ready  output  1  fetch accepts pc_addr this cycle (PC must hold when 0)
flush  input  1  redirect; kill all buffered and in-flight instructions
imem_req  output  1  memory request
imem_addr  output  32  word-aligned request address
imem_gnt  input  1  memory accepted request
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
id_valid  output  1  id_inst/id_pc valid
id_ready  input  1  decode consumes head entry
id_inst  output  32  instruction word
id_pc  output  32  address of id_inst
id_rt_addr  output  32  PC+4 of id_inst

Behaviour:
- Reset (rest_n=0, asynchronous): state IDLE, FIFO count=0, pointers 0, imem_req=0, imem_addr=0, captured tags=0, id_valid=0, id_inst=NOP_INST, id_pc=0, id_rt_addr=0, pc_ready=0 while reset asserted. Reset mid-transaction abandons the transaction; late imem_rvalid after reset in IDLE is ignored.
- At most one outstanding memory transaction.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE: pc_ready = (count < FIFO_DEPTH) && !flush. On pc_valid && pc_ready, capture pc_addr/pc_rt_addr into tag registers and go to REQ. The count check ignores a same-cycle pop.
- REQ: imem_req=1, imem_addr={tag_pc[31:2],2'b00}, both registered and stable until grant. On imem_gnt go to WAIT, or to DROP if flush is seen in the same cycle. A flush without gnt keeps the request asserted (no withdrawal) and sets a kill flag. The kill flag sends the FSM to DROP on gnt.
- WAIT: imem_req=0. On imem_rvalid, push {imem_rdata, tag_pc, tag_rt} and go to IDLE. If flush is seen in the same cycle as rvalid, discard the data and go to IDLE. A flush without rvalid goes to DROP.
- DROP: wait for imem_rvalid, discard the data, go to IDLE.
- imem_rvalid is never asserted in the same cycle as imem_gnt. It is ignored in IDLE and REQ.
- Latency: accept at edge t → imem_req high from cycle t+1. With gnt in cycle t+1 and rvalid in cycle t+2, id_valid goes high at cycle t+3 if the FIFO was empty. Peak throughput is one instruction per 3 cycles (no request pipelining).
- FIFO: id_valid = (count != 0). id_inst/id_pc/id_rt_addr come from the head entry; id_inst=NOP_INST when empty. Pop on id_valid && id_ready. Simultaneous push and pop leaves count unchanged. The credit rule guarantees a push never meets a full FIFO.
- flush: synchronous; count=0 and pointers cleared at the edge. A same-cycle pop/push is suppressed and id_valid=0 next cycle. pc_ready=0 during a flush cycle.
- Misaligned pc_addr (bits [1:0]≠0): address is forced word-aligned on imem_addr. id_pc keeps the unmodified value.
- Pointer wrap-around is modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Test Plan:
- Reset, then pc_addr=0x0 / rt 0x4 valid, gnt immediate, rvalid next cycle with 0x2002_0005, id_ready=1 → imem_addr=0x0 at cycle 1; id_valid at cycle 3 with id_inst=0x2002_0005, id_pc=0x0, id_rt_addr=0x4; popped next edge.
- id_ready=0, three fetches 0x0/0x4/0x8 → after two pushes pc_ready=0 and no third imem_req. Raising id_ready pops 0x0, then pc_ready returns and the third fetch issues.
- gnt withheld 4 cycles for pc_addr=0x40 → imem_req/imem_addr=0x40 stable all 5 cycles; WAIT is entered only after gnt.
- flush in WAIT with 1 buffered entry, rvalid two cycles later → FIFO emptied, response discarded, id_valid stays 0. The next accepted address after DROP→IDLE fetches normally.
- flush in REQ before gnt, then gnt → request held until gnt, FSM passes through DROP, the returned word is discarded.
- rest_n pulsed low in WAIT, asynchronously mid-cycle → outputs reset immediately; a later rvalid is ignored; id_valid=0.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: single-outstanding imem request, PC-tagged output FIFO, flush kill
module inst_fetch #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rest_n,
  input  logic [31:0] pc_addr,
  input  logic [31:0] pc_rt_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_rt_addr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state, state_nx;
  logic          kill, kill_nx;
  logic          accept, push, pop;
  logic [31:0]   tag_pc, tag_rt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [31:0]   mem_rt   [FIFO_DEPTH];

  // Credit check deliberately ignores a same-cycle pop to keep pc_ready off the id_ready path.
  always_comb begin
    state_nx = state;
    kill_nx  = kill;
    accept   = 1'b0;
    push     = 1'b0;
    pc_ready = rest_n && (state == IDLE) && (count < DEPTH_C) && !flush;
    case (state)
      IDLE: begin
        if (pc_valid && pc_ready) begin
          accept   = 1'b1;
          kill_nx  = 1'b0;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          state_nx = (flush || kill) ? DROP : WAIT;
          kill_nx  = 1'b0;
        end else if (flush) begin
          kill_nx = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push     = !flush;
          state_nx = IDLE;
        end else if (flush) begin
          state_nx = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop = id_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state     <= IDLE;
      kill      <= 1'b0;
      tag_pc    <= '0;
      tag_rt    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state    <= state_nx;
      kill     <= kill_nx;
      imem_req <= (state_nx == REQ);
      if (accept) begin
        tag_pc    <= pc_addr;
        tag_rt    <= pc_rt_addr;
        imem_addr <= {pc_addr[31:2], 2'b00};
      end
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= tag_pc;
      mem_rt[wr_ptr]   <= tag_rt;
    end
  end

  assign id_valid   = (count != '0);
  assign id_inst    = id_valid ? mem_inst[rd_ptr] : NOP_INST;
  assign id_pc      = id_valid ? mem_pc[rd_ptr]   : 32'h0;
  assign id_rt_addr = id_valid ? mem_rt[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized self-checking bench for inst_fetch
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rest_n;
  logic [31:0] pc_addr, pc_rt_addr;
  logic        pc_valid, pc_ready, flush;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc, id_rt_addr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: every accepted PC not yet consumed or killed, in program order.
  logic [31:0] exp_q[$];
  logic [31:0] last_acc;
  int          ph, gd, rd;
  logic [31:0] raddr;

  inst_fetch #(.FIFO_DEPTH(2), .NOP_INST(NOP)) dut (
    .clk(clk), .rest_n(rest_n),
    .pc_addr(pc_addr), .pc_rt_addr(pc_rt_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_rt_addr(id_rt_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    pc_addr = a; pc_rt_addr = a + 32'd4; pc_valid = 1'b1;
    #1;
    chk("fetch_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, {a[31:2], 2'b00});
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic rnd_cycle(input bit drain);
    tick();
    pc_valid   = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
    pc_addr    = $urandom;
    pc_rt_addr = pc_addr + 32'd4;
    id_ready   = drain ? 1'b1 : 1'($urandom_range(0, 1));
    flush      = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
    imem_gnt   = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (ph == 2) begin
      if (rd <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_f(raddr);
        ph = 0;
      end else rd--;
    end else if (ph == 1 || imem_req) begin
      if (ph == 0) begin
        ph = 1;
        gd = $urandom_range(0, 3);
        raddr = imem_addr;
        chk("rnd_req_addr", imem_addr, {last_acc[31:2], 2'b00});
      end
      if (gd == 0) begin
        imem_gnt = 1'b1;
        ph = 2;
        rd = $urandom_range(1, 3);
      end else gd--;
    end
    #1;
    if (exp_q.size() == 0) chk("rnd_empty_valid", id_valid, 0);
    if (!id_valid) chk("rnd_nop", id_inst, NOP);
    if (id_valid && id_ready && !flush) begin
      if (exp_q.size() == 0) chk("rnd_underflow", 1, 0);
      else begin
        chk("rnd_pc", id_pc, exp_q[0]);
        chk("rnd_rt", id_rt_addr, exp_q[0] + 32'd4);
        chk("rnd_inst", id_inst, mem_f({exp_q[0][31:2], 2'b00}));
        void'(exp_q.pop_front());
      end
    end
    if (flush) begin
      chk("rnd_flush_ready", pc_ready, 0);
      exp_q.delete();
    end
    if (pc_valid && pc_ready) begin
      exp_q.push_back(pc_addr);
      last_acc = pc_addr;
      chk("rnd_credit", (exp_q.size() <= 2), 1);
    end
  endtask

  initial begin
    rest_n = 1'b0; pc_addr = 0; pc_rt_addr = 0; pc_valid = 1'b1; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 0; id_ready = 1'b0;
    ph = 0; gd = 0; rd = 0; raddr = 0; last_acc = 0;
    #1;
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_inst", id_inst, NOP);
    chk("rst_pc", id_pc, 0);
    chk("rst_rt", id_rt_addr, 0);
    tick(); tick();
    rest_n = 1'b1; pc_valid = 1'b0;

    // basic fetch: id_valid three cycles after accept, popped next edge
    id_ready = 1'b1;
    do_fetch(32'h0, 32'h2002_0005);
    chk("t1_valid", id_valid, 1);
    chk("t1_inst", id_inst, 32'h2002_0005);
    chk("t1_pc", id_pc, 32'h0);
    chk("t1_rt", id_rt_addr, 32'h4);
    tick();
    chk("t1_popped", id_valid, 0);

    // back-pressure: two buffered entries block the third fetch
    id_ready = 1'b0;
    do_fetch(32'h0, 32'h1111_0001);
    do_fetch(32'h4, 32'h1111_0002);
    pc_addr = 32'h8; pc_rt_addr = 32'hC; pc_valid = 1'b1;
    #1;
    chk("t2_full_ready", pc_ready, 0);
    tick();
    chk("t2_no_req", imem_req, 0);
    id_ready = 1'b1;
    #1;
    chk("t2_pop_ready", pc_ready, 0);
    chk("t2_head0", id_pc, 32'h0);
    tick();
    id_ready = 1'b0;
    #1;
    chk("t2_ready_back", pc_ready, 1);
    chk("t2_head1", id_pc, 32'h4);
    tick();
    pc_valid = 1'b0;
    chk("t2_req3", imem_req, 1);
    chk("t2_addr3", imem_addr, 32'h8);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_0003; tick(); imem_rvalid = 1'b0;
    id_ready = 1'b1;
    chk("t2_inst1", id_inst, 32'h1111_0002);
    tick();
    chk("t2_pc2", id_pc, 32'h8);
    chk("t2_inst2", id_inst, 32'h1111_0003);
    chk("t2_rt2", id_rt_addr, 32'hC);
    tick();
    chk("t2_drained", id_valid, 0);
    id_ready = 1'b0;

    // grant withheld four cycles; stray rvalid in REQ is ignored
    pc_addr = 32'h40; pc_rt_addr = 32'h44; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_hold", imem_req, 1);
      chk("t3_addr_hold", imem_addr, 32'h40);
      if (i == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; end
      if (i == 4) imem_gnt = 1'b1;
      tick();
      imem_rvalid = 1'b0;
    end
    imem_gnt = 1'b0;
    chk("t3_req_drop", imem_req, 0);
    chk("t3_no_stray", id_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_0040; tick(); imem_rvalid = 1'b0;
    chk("t3_valid", id_valid, 1);
    chk("t3_inst", id_inst, 32'h3333_0040);
    id_ready = 1'b1; tick(); id_ready = 1'b0;

    // misaligned PC: aligned on the bus, original value reaches decode
    do_fetch(32'h43, 32'h4444_0043);
    chk("t4_pc", id_pc, 32'h43);
    chk("t4_rt", id_rt_addr, 32'h47);
    id_ready = 1'b1; tick(); id_ready = 1'b0;

    // flush in WAIT with one buffered entry
    do_fetch(32'h100, 32'h5555_0100);
    pc_addr = 32'h104; pc_rt_addr = 32'h108; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    chk("t5_buffered", id_valid, 1);
    flush = 1'b1; pc_valid = 1'b1; pc_addr = 32'h200;
    #1;
    chk("t5_flush_ready", pc_ready, 0);
    tick();
    flush = 1'b0; pc_valid = 1'b0;
    chk("t5_emptied", id_valid, 0);
    chk("t5_nop", id_inst, NOP);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_0104; tick(); imem_rvalid = 1'b0;
    chk("t5_discard", id_valid, 0);
    chk("t5_idle", pc_ready, 1);
    do_fetch(32'h200, 32'h5555_0200);
    chk("t5_refetch_pc", id_pc, 32'h200);
    chk("t5_refetch_inst", id_inst, 32'h5555_0200);
    id_ready = 1'b1; tick(); id_ready = 1'b0;

    // flush in REQ before grant
    pc_addr = 32'h300; pc_rt_addr = 32'h304; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_req_kept", imem_req, 1);
    chk("t6_addr_kept", imem_addr, 32'h300);
    tick();
    chk("t6_req_kept2", imem_req, 1);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    chk("t6_req_done", imem_req, 0);
    chk("t6_not_idle", pc_ready, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h6666_0300; tick(); imem_rvalid = 1'b0;
    chk("t6_discard", id_valid, 0);
    chk("t6_idle", pc_ready, 1);

    // asynchronous reset in WAIT
    do_fetch(32'h3F0, 32'h7777_03F0);
    chk("t7_buffered", id_valid, 1);
    pc_addr = 32'h400; pc_rt_addr = 32'h404; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    #3;
    rest_n = 1'b0; pc_valid = 1'b1;
    #1;
    chk("t7_req", imem_req, 0);
    chk("t7_addr", imem_addr, 0);
    chk("t7_valid", id_valid, 0);
    chk("t7_inst", id_inst, NOP);
    chk("t7_pc", id_pc, 0);
    chk("t7_pc_ready", pc_ready, 0);
    tick();
    rest_n = 1'b1; pc_valid = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_0400; tick(); imem_rvalid = 1'b0;
    chk("t7_late_rvalid", id_valid, 0);
    #1;
    chk("t7_idle", pc_ready, 1);

    // randomized traffic against the queue model, then drain
    for (int i = 0; i < 1500; i++) rnd_cycle(1'b0);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || ph != 0); i++) rnd_cycle(1'b1);
    chk("drain_empty", exp_q.size(), 0);
    tick();
    chk("drain_valid", id_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
